mdu_hilo: RTL and testbench

- Iterative integer multiply/divide unit with the architectural HI/LO registers.
- Sits in the EX stage beside the ALU. It takes the same input1/input2 operands from the ID/EX register.
- HI/LO feed the EX result mux for MFHI/MFLO. It executes MULT, MULTU, DIV and DIVU, which the single-cycle ALU does not implement.
- Decode stalls issue while busy is high.

---
 rtl/mdu_pkg.sv | 25 ++
 rtl/mdu_step.sv | 46 ++++
 rtl/mdu_hilo.sv | 199 +++++++++++++++++++
 tb/tb_mdu_hilo.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared encodings and defaults for the multiply/divide unit
//
// Purpose : op encodings, FSM state encoding and default sizing shared by
//           mdu_hilo and mdu_step.
package mdu_pkg;

    localparam int MDU_WIDTH = 32;
    // One result bit is produced per iteration, so the default iteration
    // count tracks the operand width.
    localparam int MDU_ITERS = MDU_WIDTH;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'b00,
        MDU_ITER = 2'b01,
        MDU_FIX  = 2'b10
    } mdu_state_e;

endpackage

// File: rtl/mdu_step.sv
// rtl/mdu_step.sv - one shift-add or restoring-subtract iteration
//
// Purpose : combinational single step of the iterative multiply/divide.
// Ports   : i_acc     [2W:0]  current accumulator
//                               multiply: {1'b0, partial_hi, multiplier/low bits}
//                               divide  : {remainder[W:0], dividend/quotient bits}
//           i_operand [W-1:0] multiplicand (multiply) or divisor (divide) magnitude
//           i_is_div          1 selects the divide step
//           o_acc     [2W:0]  accumulator after this step
module mdu_step
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic [2*WIDTH:0]  i_acc,
    input  logic [WIDTH-1:0]  i_operand,
    input  logic              i_is_div,
    output logic [2*WIDTH:0]  o_acc
);

    // Multiply: add the multiplicand into the upper half when the current
    // multiplier bit is set, then shift the whole product right by one.
    // The upper field is WIDTH+1 wide so the carry of the add is kept.
    logic [WIDTH:0]   w_sum;
    logic [2*WIDTH:0] w_mul_next;

    assign w_sum      = i_acc[2*WIDTH:WIDTH] + (i_acc[0] ? {1'b0, i_operand} : '0);
    assign w_mul_next = {1'b0, w_sum, i_acc[WIDTH-1:1]};

    // Divide: shift the next dividend bit into the remainder, try the
    // subtraction one bit wider so the borrow is visible, keep the
    // difference only when there was no borrow.
    logic [WIDTH:0]   w_shifted;
    logic [WIDTH+1:0] w_diff;
    logic             w_borrow;
    logic [2*WIDTH:0] w_div_next;

    assign w_shifted  = {i_acc[2*WIDTH-1:WIDTH], i_acc[WIDTH-1]};
    assign w_diff     = {1'b0, w_shifted} - {2'b00, i_operand};
    assign w_borrow   = w_diff[WIDTH+1];
    assign w_div_next = {(w_borrow ? w_shifted : w_diff[WIDTH:0]),
                         i_acc[WIDTH-2:0], ~w_borrow};

    assign o_acc = i_is_div ? w_div_next : w_mul_next;

endmodule

// File: rtl/mdu_hilo.sv
// rtl/mdu_hilo.sv - iterative multiply/divide unit with HI/LO registers
//
// Purpose : executes MULT/MULTU/DIV/DIVU one result bit per cycle on operand
//           magnitudes, fixes signs in a final cycle and writes HI/LO.
//           MTHI/MTLO write HI/LO directly when the unit is idle.
// Ports   : clk, rst_n          clock, async active-low reset
//           start, op[1:0]      request and operation, sampled when idle
//           input1, input2      rs (multiplicand/dividend), rt (multiplier/divisor)
//           mthi, mtlo, wdata   direct HI/LO writes
//           busy                operation in flight (ITER or FIX)
//           done, div_by_zero   one-cycle pulses after the result is written
//           hi, lo              architectural HI/LO
module mdu_hilo
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH,
    parameter int ITERS = WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(ITERS + 1);
    localparam int AW = 2 * WIDTH + 1;

    mdu_state_e       r_state;
    mdu_state_e       w_next_state;
    logic [AW-1:0]    r_acc;
    logic [AW-1:0]    w_step_acc;
    logic [WIDTH-1:0] r_operand;
    logic             r_sign1;
    logic             r_sign2;
    logic             r_is_div;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_done;
    logic             r_dbz;

    // Operand decode at start: unsigned ops keep the raw value and sign 0.
    logic             w_signed_op;
    logic             w_start_div;
    logic             w_start_dbz;
    logic             w_sign1;
    logic             w_sign2;
    logic [WIDTH-1:0] w_mag1;
    logic [WIDTH-1:0] w_mag2;

    assign w_signed_op = (op == MDU_MULT) || (op == MDU_DIV);
    assign w_start_div = (op == MDU_DIV) || (op == MDU_DIVU);
    assign w_start_dbz = w_start_div && (input2 == '0);
    assign w_sign1     = w_signed_op & input1[WIDTH-1];
    assign w_sign2     = w_signed_op & input2[WIDTH-1];
    assign w_mag1      = w_sign1 ? -input1 : input1;
    assign w_mag2      = w_sign2 ? -input2 : input2;

    mdu_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_acc     (r_acc),
        .i_operand (r_operand),
        .i_is_div  (r_is_div),
        .o_acc     (w_step_acc)
    );

    // Sign fix and result selection, consumed in FIX.
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fixed;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic               w_fix_dbz;
    logic [WIDTH-1:0]   w_fix_hi;
    logic [WIDTH-1:0]   w_fix_lo;

    assign w_prod       = r_acc[2*WIDTH-1:0];
    assign w_prod_fixed = (r_sign1 ^ r_sign2) ? -w_prod : w_prod;
    assign w_quo        = r_acc[WIDTH-1:0];
    assign w_rem        = r_acc[2*WIDTH-1:WIDTH];
    assign w_fix_dbz    = r_is_div && (r_operand == '0);

    always_comb begin
        w_fix_hi = w_prod_fixed[2*WIDTH-1:WIDTH];
        w_fix_lo = w_prod_fixed[WIDTH-1:0];
        if (w_fix_dbz) begin
            // ITER was skipped, so the low field still holds |dividend|;
            // re-applying the sign recovers the raw input1.
            w_fix_hi = r_sign1 ? -w_quo : w_quo;
            w_fix_lo = '1;
        end else if (r_is_div) begin
            w_fix_hi = r_sign1 ? -w_rem : w_rem;
            w_fix_lo = (r_sign1 ^ r_sign2) ? -w_quo : w_quo;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= MDU_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            MDU_IDLE: begin
                if (start) begin
                    w_next_state = w_start_dbz ? MDU_FIX : MDU_ITER;
                end
            end
            MDU_ITER: begin
                if (r_count == CW'(ITERS - 1)) begin
                    w_next_state = MDU_FIX;
                end
            end
            MDU_FIX: begin
                w_next_state = MDU_IDLE;
            end
            default: begin
                w_next_state = MDU_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc     <= '0;
            r_operand <= '0;
            r_sign1   <= 1'b0;
            r_sign2   <= 1'b0;
            r_is_div  <= 1'b0;
            r_count   <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_done    <= 1'b0;
            r_dbz     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_dbz  <= 1'b0;
            case (r_state)
                MDU_IDLE: begin
                    if (start) begin
                        r_is_div <= w_start_div;
                        r_sign1  <= w_sign1;
                        r_sign2  <= w_sign2;
                        r_count  <= '0;
                        // Multiply iterates over the multiplier bits held in
                        // the low field; divide shifts the dividend out of it.
                        if (w_start_div) begin
                            r_operand <= w_mag2;
                            r_acc     <= {{(WIDTH + 1){1'b0}}, w_mag1};
                        end else begin
                            r_operand <= w_mag1;
                            r_acc     <= {{(WIDTH + 1){1'b0}}, w_mag2};
                        end
                    end else begin
                        if (mthi) begin
                            r_hi <= wdata;
                        end
                        if (mtlo) begin
                            r_lo <= wdata;
                        end
                    end
                end
                MDU_ITER: begin
                    r_acc   <= w_step_acc;
                    r_count <= r_count + CW'(1);
                end
                MDU_FIX: begin
                    r_hi   <= w_fix_hi;
                    r_lo   <= w_fix_lo;
                    r_done <= 1'b1;
                    r_dbz  <= w_fix_dbz;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy        = (r_state != MDU_IDLE);
    assign done        = r_done;
    assign div_by_zero = r_dbz;
    assign hi          = r_hi;
    assign lo          = r_lo;

endmodule

// File: tb/tb_mdu_hilo.sv
// tb/tb_mdu_hilo.sv - self-checking bench for mdu_hilo
module tb_mdu_hilo;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] input1;
    logic [31:0] input2;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_vec = 0;
    int n_bad = 0;

    mdu_hilo #(
        .WIDTH (32),
        .ITERS (32)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .op          (op),
        .input1      (input1),
        .input2      (input2),
        .mthi        (mthi),
        .mtlo        (mtlo),
        .wdata       (wdata),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          lat;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic; SV / and % truncate toward zero
    // and the remainder follows the dividend sign, as the unit requires.
    function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] mhi, output logic [31:0] mlo,
                                  output logic mdbz);
        longint          sa;
        longint          sb;
        longint          p;
        longint unsigned ua;
        longint unsigned ub;
        longint unsigned up;
        sa   = $signed(a);
        sb   = $signed(b);
        ua   = a;
        ub   = b;
        mdbz = 1'b0;
        mhi  = '0;
        mlo  = '0;
        if (o[1] && b == 0) begin
            mdbz = 1'b1;
            mhi  = a;
            mlo  = 32'hFFFF_FFFF;
        end else begin
            case (o)
                2'b00: begin p = sa * sb;  mhi = p[63:32];  mlo = p[31:0];  end
                2'b01: begin up = ua * ub; mhi = up[63:32]; mlo = up[31:0]; end
                2'b10: begin p = sa / sb;  mlo = p[31:0]; p = sa % sb; mhi = p[31:0]; end
                default: begin up = ua / ub; mlo = up[31:0]; up = ua % ub; mhi = up[31:0]; end
            endcase
        end
    endfunction

    // Called at a negedge; returns at the negedge where done is seen.
    // lat counts edges after the start edge until done is visible.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int inj, output int lat, output int busy_n,
                          output logic busy_at_done);
        op     = o;
        input1 = a;
        input2 = b;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        mthi   = 1'b0;
        mtlo   = 1'b0;
        lat    = 0;
        busy_n = 0;
        while (!done && lat < 100) begin
            if (busy) busy_n++;
            if (lat == inj) begin
                start  = 1'b1;
                mtlo   = 1'b1;
                wdata  = 32'hDEAD_BEEF;
                op     = ~o;
                input1 = 32'h11;
                input2 = 32'h0;
            end else begin
                start = 1'b0;
                mtlo  = 1'b0;
            end
            lat++;
            @(negedge clk);
        end
        start        = 1'b0;
        mtlo         = 1'b0;
        busy_at_done = busy;
    endtask

    vec_t        tbl[10];
    int          lat;
    int          bn;
    logic        bad;
    logic [31:0] ehi;
    logic [31:0] elo;
    logic        edbz;
    logic        saw_done;

    initial begin
        tbl[0] = '{2'b00, 32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 33};
        tbl[1] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 33};
        tbl[2] = '{2'b11, 32'd100,       32'd7,        32'h0000_0002, 32'h0000_000E, 1'b0, 33};
        tbl[3] = '{2'b10, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33};
        tbl[4] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 33};
        tbl[5] = '{2'b10, 32'd5,         32'd0,        32'h0000_0005, 32'hFFFF_FFFF, 1'b1, 1};
        tbl[6] = '{2'b00, 32'h1234_5678, 32'd0,        32'h0000_0000, 32'h0000_0000, 1'b0, 33};
        tbl[7] = '{2'b10, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 33};
        tbl[8] = '{2'b11, 32'd5,         32'd0,        32'h0000_0005, 32'hFFFF_FFFF, 1'b1, 1};
        tbl[9] = '{2'b10, 32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1, 1};

        rst_n  = 1'b0;
        start  = 1'b0;
        op     = 2'b00;
        input1 = '0;
        input2 = '0;
        mthi   = 1'b0;
        mtlo   = 1'b0;
        wdata  = '0;
        repeat (2) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_dbz", div_by_zero, 0);
        chk("reset_hi", hi, 0);
        chk("reset_lo", lo, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table vectors, issued back-to-back in each done cycle.
        for (int i = 0; i < 10; i++) begin
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, -1, lat, bn, bad);
            chk($sformatf("tbl%0d_hi", i), hi, tbl[i].hi);
            chk($sformatf("tbl%0d_lo", i), lo, tbl[i].lo);
            chk($sformatf("tbl%0d_dbz", i), div_by_zero, tbl[i].dbz);
            chk($sformatf("tbl%0d_lat", i), lat, tbl[i].lat);
            chk($sformatf("tbl%0d_busy_cycles", i), bn, tbl[i].lat);
            chk($sformatf("tbl%0d_busy_at_done", i), bad, 0);
        end
        @(negedge clk);
        chk("dbz_pulse_width", div_by_zero, 0);
        chk("done_pulse_width_dbz", done, 0);

        // MTHI, then MTHI+MTLO together.
        mthi  = 1'b1;
        wdata = 32'h0000_1234;
        @(negedge clk);
        mthi = 1'b0;
        chk("mthi_hi", hi, 32'h0000_1234);
        chk("mthi_lo_kept", lo, 32'hFFFF_FFFF);
        mthi  = 1'b1;
        mtlo  = 1'b1;
        wdata = 32'hCAFE_F00D;
        @(negedge clk);
        mthi = 1'b0;
        mtlo = 1'b0;
        chk("mthilo_hi", hi, 32'hCAFE_F00D);
        chk("mthilo_lo", lo, 32'hCAFE_F00D);

        // Start has priority over a simultaneous MTHI.
        mthi  = 1'b1;
        wdata = 32'h5555_5555;
        run_op(2'b00, 32'd6, 32'd7, -1, lat, bn, bad);
        chk("prio_hi", hi, 32'h0);
        chk("prio_lo", lo, 32'd42);

        // MTLO and a second start mid-operation are ignored.
        run_op(2'b00, 32'hFFFF_FFFA, 32'd7, 5, lat, bn, bad);
        chk("inject_hi", hi, 32'hFFFF_FFFF);
        chk("inject_lo", lo, 32'hFFFF_FFD6);
        chk("inject_lat", lat, 33);
        chk("inject_dbz", div_by_zero, 0);
        @(negedge clk);
        chk("done_pulse_width", done, 0);
        chk("inject_no_restart", busy, 0);

        // Randomized operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            logic [1:0]  ro;
            logic [31:0] ra;
            logic [31:0] rb;
            ro = 2'($urandom_range(0, 3));
            ra = $urandom();
            rb = $urandom();
            case ($urandom_range(0, 7))
                0: rb = 32'h0;
                1: rb = 32'($urandom_range(1, 15));
                2: ra = 32'h8000_0000;
                3: rb = 32'hFFFF_FFFF;
                default: ;
            endcase
            model(ro, ra, rb, ehi, elo, edbz);
            run_op(ro, ra, rb, -1, lat, bn, bad);
            chk($sformatf("rnd%0d_op%0d_%h_%h_hi", i, ro, ra, rb), hi, ehi);
            chk($sformatf("rnd%0d_op%0d_%h_%h_lo", i, ro, ra, rb), lo, elo);
            chk($sformatf("rnd%0d_dbz", i), div_by_zero, edbz);
            chk($sformatf("rnd%0d_lat", i), lat, edbz ? 1 : 33);
        end
        @(negedge clk);

        // Asynchronous reset during iteration 10 of a DIV.
        op     = 2'b10;
        input1 = 32'd1000;
        input2 = 32'd3;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        chk("pre_reset_busy", busy, 1);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_busy", busy, 0);
        chk("async_rst_done", done, 0);
        chk("async_rst_hi", hi, 0);
        chk("async_rst_lo", lo, 0);
        @(negedge clk);
        rst_n    = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        chk("no_done_after_reset", saw_done, 0);
        run_op(2'b00, 32'd6, 32'd7, -1, lat, bn, bad);
        chk("post_reset_lo", lo, 32'd42);
        chk("post_reset_hi", hi, 32'd0);
        chk("post_reset_lat", lat, 33);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
